// File: rtl/twiddle_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : twiddle_seq_pkg
// Purpose  : Shared constants, types and helpers for the twiddle sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package twiddle_seq_pkg;

    localparam int TW_TABLE_AW = 6;

    // Bit-reversed group multiplier, 2 bits per group: grp0->0, grp1->2, grp2->1, grp3->3
    localparam logic [7:0] TW_GRP_SEL = 8'b11_01_10_00;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef struct packed {
        logic bypass;
        logic first;
        logic last;
    } tw_flags_t;

    function automatic logic [1:0] tw_grp_sel(input logic [1:0] grp);
        return TW_GRP_SEL[{grp, 1'b0} +: 2];
    endfunction

    // The 64-entry table only holds k, 2k and 3k for k = 0..15
    function automatic logic tw_populated(input logic [TW_TABLE_AW-1:0] addr);
        int v;
        v = int'(addr);
        return (v <= 15) || ((v <= 30) && (v % 2 == 0)) || ((v <= 45) && (v % 3 == 0));
    endfunction

endpackage
`default_nettype wire

// File: rtl/twiddle_seq_align_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tw_align_pipe
// Purpose  : Fixed-depth valid/flag delay line aligning control with table data.
// Revision : 1.0 - initial release
// ============================================================================
module tw_align_pipe #(
    parameter int DEPTH  = 2,
    parameter int FLAG_W = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              din_valid,
    input  logic [FLAG_W-1:0] din_flags,
    output logic              dout_valid,
    output logic [FLAG_W-1:0] dout_flags,
    output logic              any_valid
);

    logic [DEPTH-1:0]  r_valid;
    logic [FLAG_W-1:0] r_flags [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_valid[0] <= 1'b0;
                    r_flags[0] <= '0;
                end else begin
                    r_valid[0] <= din_valid;
                    r_flags[0] <= din_flags;
                end
            end
        end else begin : g_tail
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_valid[g] <= 1'b0;
                    r_flags[g] <= '0;
                end else begin
                    r_valid[g] <= r_valid[g-1];
                    r_flags[g] <= r_flags[g-1];
                end
            end
        end
    end

    assign dout_valid = r_valid[DEPTH-1];
    assign dout_flags = r_flags[DEPTH-1];
    assign any_valid  = |r_valid;

endmodule
`default_nettype wire

// File: rtl/twiddle_seq.sv
`default_nettype none
// ============================================================================
// Module   : twiddle_seq
// Purpose  : Twiddle table address sequencer and aligned multiplier control.
// Revision : 1.0 - initial release
// ============================================================================
module twiddle_seq
    import twiddle_seq_pkg::*;
#(
    parameter int LOG_N = 6,   // 4..6
    parameter int TW_FF = 1    // 0 or 1, must match the table output register
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   di_en,
    input  logic                   sync,
    output logic [TW_TABLE_AW-1:0] tw_addr,
    output logic                   mul_en,
    output logic                   mul_bypass,
    output logic                   frame_start,
    output logic                   frame_last,
    output logic                   busy
);

    localparam int             c_depth   = 1 + TW_FF;
    localparam logic [LOG_N-1:0] c_cnt_max = '1;

    logic [LOG_N-1:0]       r_cnt;
    logic [0:0]             r_state;
    logic [TW_TABLE_AW-1:0] r_tw_addr;

    logic [LOG_N-1:0]       w_c;
    logic [1:0]             w_grp;
    logic [LOG_N-3:0]       w_idx;
    logic [LOG_N-1:0]       w_sel_x;
    logic [LOG_N-1:0]       w_idx_x;
    logic [LOG_N-1:0]       w_n;
    logic [TW_TABLE_AW-1:0] w_n_x;
    logic [TW_TABLE_AW-1:0] w_addr;
    tw_flags_t              w_flags_in;
    tw_flags_t              w_flags_out;
    logic                   w_pipe_valid;
    logic                   w_pipe_busy;

    // A sync arriving with a sample makes that sample number 0
    assign w_c     = sync ? '0 : r_cnt;
    assign w_grp   = w_c[LOG_N-1 -: 2];
    assign w_idx   = w_c[LOG_N-3:0];
    assign w_sel_x = {{(LOG_N-2){1'b0}}, tw_grp_sel(w_grp)};
    assign w_idx_x = {2'b00, w_idx};
    assign w_n     = w_sel_x * w_idx_x;
    assign w_n_x   = TW_TABLE_AW'(w_n);
    assign w_addr  = w_n_x << (TW_TABLE_AW - LOG_N);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_state   <= ST_IDLE;
            r_tw_addr <= '0;
        end else if (di_en) begin
            r_cnt     <= w_c + LOG_N'(1);
            r_tw_addr <= w_addr;
            r_state   <= (w_c == c_cnt_max) ? ST_IDLE : ST_RUN;
        end else if (sync) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
        end
    end

    assign w_flags_in.bypass = di_en & (w_n == '0);
    assign w_flags_in.first  = di_en & (w_c == '0);
    assign w_flags_in.last   = di_en & (w_c == c_cnt_max);

    tw_align_pipe #(
        .DEPTH  (c_depth),
        .FLAG_W ($bits(tw_flags_t))
    ) u_align (
        .clock      (clock),
        .reset_n    (reset_n),
        .din_valid  (di_en),
        .din_flags  (w_flags_in),
        .dout_valid (w_pipe_valid),
        .dout_flags (w_flags_out),
        .any_valid  (w_pipe_busy)
    );

    assign tw_addr     = r_tw_addr;
    assign mul_en      = w_pipe_valid;
    assign mul_bypass  = w_flags_out.bypass;
    assign frame_start = w_flags_out.first;
    assign frame_last  = w_flags_out.last;
    assign busy        = (r_state == ST_RUN) | w_pipe_busy;

    if (LOG_N == 6) begin : g_chk_table
        a_tw_populated: assert property (
            @(posedge clock) disable iff (!reset_n) di_en |-> tw_populated(w_addr)
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_twiddle_seq.sv
`timescale 1ns/1ps
// Scoreboard bench for twiddle_seq: three instances (64/TW_FF=1, 64/TW_FF=0,
// 16/TW_FF=1) share one stimulus stream; each has its own expected queue.
module tb_twiddle_seq;

    typedef struct {
        logic [8:0] val;   // {tw_addr, bypass, first, last}
        int         cyc;
    } exp_t;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       di_en   = 1'b0;
    logic       sync    = 1'b0;
    logic [5:0] addr [3];
    logic       men [3];
    logic       byp [3];
    logic       fst [3];
    logic       lst [3];
    logic       bsy [3];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int c_log [3] = '{6, 6, 4};
    int c_ff  [3] = '{1, 0, 1};
    int c_sel [4] = '{0, 2, 1, 3};
    int mcnt  [3] = '{0, 0, 0};
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    twiddle_seq #(.LOG_N(6), .TW_FF(1)) u_dut_a (
        .clock(clock), .reset_n(reset_n), .di_en(di_en), .sync(sync),
        .tw_addr(addr[0]), .mul_en(men[0]), .mul_bypass(byp[0]),
        .frame_start(fst[0]), .frame_last(lst[0]), .busy(bsy[0]));

    twiddle_seq #(.LOG_N(6), .TW_FF(0)) u_dut_b (
        .clock(clock), .reset_n(reset_n), .di_en(di_en), .sync(sync),
        .tw_addr(addr[1]), .mul_en(men[1]), .mul_bypass(byp[1]),
        .frame_start(fst[1]), .frame_last(lst[1]), .busy(bsy[1]));

    twiddle_seq #(.LOG_N(4), .TW_FF(1)) u_dut_c (
        .clock(clock), .reset_n(reset_n), .di_en(di_en), .sync(sync),
        .tw_addr(addr[2]), .mul_en(men[2]), .mul_bypass(byp[2]),
        .frame_start(fst[2]), .frame_last(lst[2]), .busy(bsy[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push(input int k, input exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t pop(input int k);
        case (k)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Reference: n = {0,2,1,3}[grp] * idx mod 2^L, scaled to the 64-entry table
    function automatic exp_t model(input int k, input int c);
        exp_t e;
        int   l, n, a;
        l = c_log[k];
        n = (c_sel[c >> (l - 2)] * (c & ((1 << (l - 2)) - 1))) % (1 << l);
        a = n << (6 - l);
        e.val = {a[5:0], (n == 0), (c == 0), (c == (1 << l) - 1)};
        e.cyc = cyc + 1 + c_ff[k];
        return e;
    endfunction

    task automatic step(input logic d, input logic s);
        int c;
        @(negedge clock);
        di_en = d;
        sync  = s;
        for (int k = 0; k < 3; k++) begin
            if (d) begin
                c = s ? 0 : mcnt[k];
                push(k, model(k, c));
                mcnt[k] = (c + 1) % (1 << c_log[k]);
            end else if (s) begin
                mcnt[k] = 0;
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int k = 0; k < 3; k++)
            chk($sformatf("%s_outputs_%0d", tag, k),
                {21'd0, addr[k], men[k], byp[k], fst[k], lst[k], bsy[k]}, 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset_n = 1'b0;
        di_en   = 1'b0;
        sync    = 1'b0;
        q0.delete();
        q1.delete();
        q2.delete();
        for (int k = 0; k < 3; k++) mcnt[k] = 0;
        #1;
        check_reset_state("async_reset");
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic check_busy(input string tag, input logic exp);
        for (int k = 0; k < 3; k++)
            chk($sformatf("%s_busy_%0d", tag, k), {31'd0, bsy[k]}, {31'd0, exp});
    endtask

    // Monitor: pop an expectation whenever an instance presents mul_en
    logic [5:0] prev_addr [3] = '{6'd0, 6'd0, 6'd0};
    always begin
        exp_t       e;
        logic [5:0] act_addr;
        @(posedge clock);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (men[k]) begin
                if (qsize(k) == 0) begin
                    chk($sformatf("spurious_mul_en_%0d", k), 32'd1, 32'd0);
                end else begin
                    e = pop(k);
                    act_addr = (c_ff[k] != 0) ? prev_addr[k] : addr[k];
                    chk($sformatf("out_%0d", k),
                        {23'd0, act_addr, byp[k], fst[k], lst[k]}, {23'd0, e.val});
                    chk($sformatf("latency_%0d", k), cyc, e.cyc);
                end
            end else if (byp[k] | fst[k] | lst[k]) begin
                chk($sformatf("flag_without_mul_en_%0d", k), 32'd1, 32'd0);
            end
            prev_addr[k] = addr[k];
        end
    end

    initial begin
        repeat (2) @(negedge clock);
        #1;
        check_reset_state("initial_reset");
        @(negedge clock);
        reset_n = 1'b1;

        // Back-to-back frames: 1 frame at 64 points, 4 frames at 16 points
        for (int i = 0; i < 64; i++) step(1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b0);
        check_busy("after_frame", 1'b0);

        // Sparse input 1,0,0: gaps must not disturb the address sequence
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
            if (i == 10) check_busy("mid_sparse", 1'b1);
        end
        repeat (6) step(1'b0, 1'b0);
        check_busy("after_sparse", 1'b0);

        // Frame restart with sync on sample 20
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 63; i++) step(1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b0);
        check_busy("after_sync", 1'b0);

        // Reset in the middle of a frame, then a clean frame from count 0
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0);
        pulse_reset();
        for (int i = 0; i < 64; i++) step(1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b0);
        check_busy("final", 1'b0);
        for (int k = 0; k < 3; k++)
            chk($sformatf("queue_drained_%0d", k), qsize(k), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
